// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution job scheduler.
package conv_pkg;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 5;

    localparam logic [ADDR_W-1:0] IMG_STRIDE = 8'd16;
    localparam logic [CNT_W-1:0]  MAX_IMGS   = 5'd16;

    typedef enum logic [3:0] {
        IDLE,
        RD_GO,
        RD_WAIT,
        CV_GO,
        CV_WAIT,
        WR_GO,
        WR_WAIT,
        NEXT,
        FIN
    } sched_state_t;

    // A zero count still processes one image; oversize counts saturate.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] cnt);
        if (cnt == '0) begin
            return CNT_W'(1);
        end else if (cnt > MAX_IMGS) begin
            return MAX_IMGS;
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Phase watchdog: counts cycles spent waiting and flags when WDOG_CYC-1 is reached.
module sched_watchdog #(
    parameter int WDOG_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(WDOG_CYC);

    logic [CW-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (cnt_q == CW'(WDOG_CYC - 1));

endmodule

// File: rtl/conv_job_scheduler.sv
// Batch scheduler: walks each image of a job through read, convolve and write
// phases, with abort at phase boundaries and a per-phase watchdog.
module conv_job_scheduler
    import conv_pkg::*;
#(
    parameter int WDOG_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_img_base,
    input  logic [ADDR_W-1:0] job_flt_base,
    input  logic [ADDR_W-1:0] job_out_base,
    input  logic [CNT_W-1:0]  job_count,
    input  logic              abort,
    output logic              rd_start,
    output logic [ADDR_W-1:0] rd_x,
    output logic [ADDR_W-1:0] rd_y,
    output logic [ADDR_W-1:0] rd_z,
    input  logic              rd_done,
    output logic              conv_start,
    input  logic              conv_done,
    output logic              wr_start,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_done,
    output logic              busy,
    output logic [CNT_W-1:0]  img_idx,
    output logic              job_done,
    output logic              err
);

    sched_state_t      state_q;
    logic              job_ready_q, busy_q, job_done_q, err_q;
    logic              rd_start_q, conv_start_q, wr_start_q;
    logic              abort_pend_q, abort_pend_d;
    logic [CNT_W-1:0]  img_idx_q, count_q;
    logic [ADDR_W-1:0] img_addr_q, flt_addr_q, out_addr_q;
    logic [ADDR_W-1:0] img_addr_d, out_addr_d;
    logic              last_img, wd_clr, wd_en, wd_expired;

    always_comb begin
        // NOTE: default assignment first keeps this block from inferring a latch.
        abort_pend_d = abort_pend_q;
        if (busy_q && abort) begin
            abort_pend_d = 1'b1;
        end
    end

    // Addresses advance by stride rather than multiplying the index each image.
    assign img_addr_d = img_addr_q + IMG_STRIDE;
    assign out_addr_d = out_addr_q + IMG_STRIDE;
    assign last_img   = (img_idx_q == count_q - CNT_W'(1));

    assign wd_clr = state_q inside {RD_GO, CV_GO, WR_GO};
    assign wd_en  = state_q inside {RD_WAIT, CV_WAIT, WR_WAIT};

    sched_watchdog #(
        .WDOG_CYC(WDOG_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            job_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            job_done_q   <= 1'b0;
            err_q        <= 1'b0;
            rd_start_q   <= 1'b0;
            conv_start_q <= 1'b0;
            wr_start_q   <= 1'b0;
            abort_pend_q <= 1'b0;
            img_idx_q    <= '0;
            count_q      <= '0;
            img_addr_q   <= '0;
            flt_addr_q   <= '0;
            out_addr_q   <= '0;
        end else begin
            rd_start_q   <= 1'b0;
            conv_start_q <= 1'b0;
            wr_start_q   <= 1'b0;
            job_done_q   <= 1'b0;
            abort_pend_q <= abort_pend_d;
            case (state_q)
                IDLE: begin
                    if (job_valid && job_ready_q) begin
                        state_q      <= RD_GO;
                        job_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        rd_start_q   <= 1'b1;
                        err_q        <= 1'b0;
                        abort_pend_q <= 1'b0;
                        img_idx_q    <= '0;
                        count_q      <= clamp_count(job_count);
                        img_addr_q   <= job_img_base;
                        flt_addr_q   <= job_flt_base;
                        out_addr_q   <= job_out_base;
                    end
                end
                RD_GO: state_q <= RD_WAIT;
                RD_WAIT: begin
                    if (rd_done) begin
                        state_q      <= CV_GO;
                        conv_start_q <= 1'b1;
                    end else if (wd_expired) begin
                        state_q    <= FIN;
                        err_q      <= 1'b1;
                        job_done_q <= 1'b1;
                    end
                end
                CV_GO: state_q <= CV_WAIT;
                CV_WAIT: begin
                    if (conv_done) begin
                        state_q    <= WR_GO;
                        wr_start_q <= 1'b1;
                    end else if (wd_expired) begin
                        state_q    <= FIN;
                        err_q      <= 1'b1;
                        job_done_q <= 1'b1;
                    end
                end
                WR_GO: state_q <= WR_WAIT;
                WR_WAIT: begin
                    if (wr_done) begin
                        state_q <= NEXT;
                    end else if (wd_expired) begin
                        state_q    <= FIN;
                        err_q      <= 1'b1;
                        job_done_q <= 1'b1;
                    end
                end
                NEXT: begin
                    if (last_img || abort_pend_d) begin
                        state_q    <= FIN;
                        job_done_q <= 1'b1;
                    end else begin
                        state_q    <= RD_GO;
                        rd_start_q <= 1'b1;
                        img_idx_q  <= img_idx_q + CNT_W'(1);
                        img_addr_q <= img_addr_d;
                        out_addr_q <= out_addr_d;
                    end
                end
                FIN: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    job_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign job_ready  = job_ready_q;
    assign busy       = busy_q;
    assign job_done   = job_done_q;
    assign err        = err_q;
    assign rd_start   = rd_start_q;
    assign conv_start = conv_start_q;
    assign wr_start   = wr_start_q;
    assign img_idx    = img_idx_q;
    assign rd_x       = img_addr_q;
    assign rd_y       = flt_addr_q;
    assign rd_z       = out_addr_q;
    assign wr_addr    = out_addr_q;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Self-checking bench: a randomised done responder logs every start pulse and the
// log is compared against the image sequence computed directly from the job fields.
module tb_conv_job_scheduler;

    localparam int STRIDE = 16;
    localparam int MAX_N  = 16;
    localparam int WDOG   = 1024;

    typedef struct packed {
        logic [1:0] ph;   // 0 read, 1 conv, 2 write
        logic [4:0] idx;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
        logic [7:0] gap;  // cycles from previous phase done to this start
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       job_valid = 1'b0;
    logic       job_ready;
    logic [7:0] job_img_base = '0, job_flt_base = '0, job_out_base = '0;
    logic [4:0] job_count = '0;
    logic       abort = 1'b0;
    logic       rd_start, conv_start, wr_start;
    logic [7:0] rd_x, rd_y, rd_z, wr_addr;
    logic       rd_done = 1'b0, conv_done = 1'b0, wr_done = 1'b0;
    logic       busy, job_done, err;
    logic [4:0] img_idx;

    int n_checks = 0;
    int n_errors = 0;

    // responder / monitor state
    int   cyc = 0;
    int   jd_cnt = 0, jd_cyc = 0, cv_start_cyc = 0, rd_done_cyc = 0, cv_done_cyc = 0;
    int   unstable = 0;
    int   rd_cnt = 0, cv_cnt = 0, wr_cnt = 0;
    bit   rd_pend = 0, cv_pend = 0, wr_pend = 0, abort_arm = 0;
    logic [7:0] ax = '0, ay = '0, az = '0, wz = '0;
    ev_t  log_q[$];

    // responder knobs
    int delay_fixed = 3;
    bit coin_en = 0, stray_en = 0, abort_force = 0, force_rd = 0;
    int abort_img = -1, withhold_img = -1;

    conv_job_scheduler #(.WDOG_CYC(WDOG)) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_img_base(job_img_base),
        .job_flt_base(job_flt_base),
        .job_out_base(job_out_base),
        .job_count   (job_count),
        .abort       (abort),
        .rd_start    (rd_start),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_z        (rd_z),
        .rd_done     (rd_done),
        .conv_start  (conv_start),
        .conv_done   (conv_done),
        .wr_start    (wr_start),
        .wr_addr     (wr_addr),
        .wr_done     (wr_done),
        .busy        (busy),
        .img_idx     (img_idx),
        .job_done    (job_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick_delay();
        return (delay_fixed > 0) ? delay_fixed : int'($urandom_range(4, 1));
    endfunction

    function automatic int clamp_n(input int c);
        if (c == 0) return 1;
        if (c > MAX_N) return MAX_N;
        return c;
    endfunction

    // Done responder and start-pulse logger, acting on the falling edge.
    initial forever begin
        @(negedge clk);
        rd_done = 1'b0; conv_done = 1'b0; wr_done = 1'b0;
        abort = abort_force;
        if (rst) begin
            rd_pend = 0; cv_pend = 0; wr_pend = 0; abort_arm = 0;
        end else begin
            if (abort_arm) begin abort = 1'b1; abort_arm = 0; end
            if (rd_pend && (rd_x !== ax || rd_y !== ay || rd_z !== az)) unstable++;
            if (wr_pend && wr_addr !== wz) unstable++;
            if (rd_pend && rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin rd_done = 1'b1; rd_pend = 0; rd_done_cyc = cyc; end
            end
            if (cv_pend && cv_cnt > 0) begin
                cv_cnt--;
                if (cv_cnt == 0) begin conv_done = 1'b1; cv_pend = 0; cv_done_cyc = cyc; end
            end
            if (wr_pend && wr_cnt > 0) begin
                wr_cnt--;
                if (wr_cnt == 0) begin wr_done = 1'b1; wr_pend = 0; end
            end
            if (rd_start) begin
                log_q.push_back({2'd0, img_idx, rd_x, rd_y, rd_z, 8'd0});
                ax = rd_x; ay = rd_y; az = rd_z;
                rd_pend = 1; rd_cnt = pick_delay();
                if (coin_en && $urandom_range(1) == 1) rd_done = 1'b1;
            end
            if (conv_start) begin
                log_q.push_back({2'd1, img_idx, rd_x, rd_y, rd_z, 8'(cyc - rd_done_cyc)});
                cv_pend = 1; cv_start_cyc = cyc;
                cv_cnt = (int'(img_idx) == withhold_img) ? 0 : pick_delay();
                if (coin_en && $urandom_range(1) == 1) conv_done = 1'b1;
                if (abort_img >= 0 && int'(img_idx) == abort_img) abort_arm = 1;
            end
            if (wr_start) begin
                log_q.push_back({2'd2, img_idx, rd_x, rd_y, wr_addr, 8'(cyc - cv_done_cyc)});
                wz = wr_addr; wr_pend = 1; wr_cnt = pick_delay();
                if (coin_en && $urandom_range(1) == 1) wr_done = 1'b1;
            end
            if (stray_en) begin
                if (!rd_pend && $urandom_range(7) == 0) rd_done = 1'b1;
                if (!cv_pend && $urandom_range(7) == 0) conv_done = 1'b1;
                if (!wr_pend && $urandom_range(7) == 0) wr_done = 1'b1;
            end
            if (force_rd) rd_done = 1'b1;
            if (job_done) begin
                jd_cnt++; jd_cyc = cyc;
                rd_pend = 0; cv_pend = 0; wr_pend = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Submit one job, wait for its completion and compare the logged start pulses.
    task automatic run_job(input logic [7:0] ib, input logic [7:0] fb, input logic [7:0] ob,
                           input logic [4:0] cnt, input int ab, input int wh);
        ev_t exp_q[$];
        int  n, last, m;
        logic [7:0] x, z;
        n = clamp_n(int'(cnt));
        last = n - 1;
        if (ab >= 0 && ab < last) last = ab;
        if (wh >= 0 && wh < last) last = wh;
        for (int i = 0; i <= last; i++) begin
            x = 8'((int'(ib) + STRIDE * i) % 256);
            z = 8'((int'(ob) + STRIDE * i) % 256);
            exp_q.push_back({2'd0, 5'(i), x, fb, z, 8'd0});
            exp_q.push_back({2'd1, 5'(i), x, fb, z, 8'd1});
            if (i != wh) exp_q.push_back({2'd2, 5'(i), x, fb, z, 8'd1});
        end

        log_q.delete();
        jd_cnt = 0; unstable = 0;
        abort_img = ab; withhold_img = wh;
        step();
        job_valid = 1'b1;
        job_img_base = ib; job_flt_base = fb; job_out_base = ob; job_count = cnt;
        step();
        job_valid = 1'b0;
        check("accept_ready", job_ready, 1'b0);
        check("accept_busy", busy, 1'b1);
        check("accept_rd_start", rd_start, 1'b1);
        check("accept_err_clr", err, 1'b0);
        for (int c = 0; c < 5000 && jd_cnt == 0; c++) step();
        step();
        check("job_done_pulses", jd_cnt, 1);
        check("end_busy", busy, 1'b0);
        check("end_ready", job_ready, 1'b1);
        check("end_img_idx", img_idx, 5'(last));
        check("end_err", err, (wh >= 0) ? 1'b1 : 1'b0);
        check("addr_stable", unstable, 0);
        check("ev_count", log_q.size(), exp_q.size());
        m = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check($sformatf("ev%0d", i), log_q[i], exp_q[i]);
        abort_img = -1; withhold_img = -1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int n;
        int ab;
        logic [4:0] cnt;

        repeat (3) step();
        check("rst_ready", job_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_starts", {rd_start, conv_start, wr_start, job_done, err}, 5'b0);
        check("rst_idx", img_idx, 5'd0);
        check("rst_addr", {rd_x, rd_y, rd_z, wr_addr}, 32'd0);
        rst = 1'b0;

        // stray rd_done and abort while idle must change nothing
        force_rd = 1; abort_force = 1;
        repeat (4) begin
            step();
            check("idle_stray_busy", busy, 1'b0);
            check("idle_stray_rd_start", rd_start, 1'b0);
        end
        force_rd = 0; abort_force = 0;
        step();
        check("idle_stray_ready", job_ready, 1'b1);

        delay_fixed = 3;
        run_job(8'hF0, 8'h33, 8'h05, 5'd3, -1, -1);
        run_job(8'h10, 8'h80, 8'hC0, 5'd1, -1, -1);

        delay_fixed = 1; coin_en = 1;
        run_job(8'h22, 8'h44, 8'h66, 5'd0, -1, -1);
        run_job(8'h01, 8'h02, 8'h03, 5'd31, -1, -1);

        delay_fixed = 2; coin_en = 0;
        run_job(8'h40, 8'h50, 8'h60, 5'd4, 1, -1);

        run_job(8'hA0, 8'hB0, 8'hC0, 5'd2, -1, 0);
        check("wdog_latency", jd_cyc - cv_start_cyc, WDOG + 1);
        repeat (3) step();
        check("err_sticky", err, 1'b1);

        delay_fixed = 0; coin_en = 1; stray_en = 1;
        for (int j = 0; j < 8; j++) begin
            cnt = 5'($urandom_range(31));
            n = clamp_n(int'(cnt));
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(n - 1)) : -1;
            run_job(8'($urandom), 8'($urandom), 8'($urandom), cnt, ab, -1);
        end

        // reset while waiting for the writer
        delay_fixed = 4; coin_en = 0; stray_en = 0;
        jd_cnt = 0;
        step();
        job_valid = 1'b1;
        job_img_base = 8'h12; job_flt_base = 8'h34; job_out_base = 8'h56; job_count = 5'd2;
        step();
        job_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            if (wr_start) found = 1;
        end
        check("rst_reach_wr_wait", found, 1'b1);
        step();
        rst = 1'b1;
        step();
        check("midrst_ready", job_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_idx", img_idx, 5'd0);
        check("midrst_addr", rd_x, 8'd0);
        rst = 1'b0;
        repeat (4) step();
        check("midrst_no_done", jd_cnt, 0);

        delay_fixed = 0; coin_en = 1; stray_en = 1;
        run_job(8'h7F, 8'h01, 8'hFE, 5'd5, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
